sisc_mc_ctrl: RTL and testbench



---
 rtl/sisc_pkg.sv | 30 +++
 rtl/sisc_mc_ctrl_if.sv | 41 ++++
 rtl/sisc_wait_timer.sv | 28 ++
 rtl/sisc_mc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sisc_mc_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC multi-cycle controller: opcodes, ALU codes, state encoding.
// CALL/RET decoding is enabled elsewhere by the SISC_CALLRET_EN macro.
package sisc_pkg;

  localparam int unsigned WaitW = 8;

  localparam int unsigned OpNop   = 0;
  localparam int unsigned OpRegOp = 1;
  localparam int unsigned OpRegIm = 2;
  localparam int unsigned OpBra   = 4;
  localparam int unsigned OpBrr   = 5;
  localparam int unsigned OpBne   = 6;
  localparam int unsigned OpBnr   = 7;
  localparam int unsigned OpLod   = 10;
  localparam int unsigned OpStr   = 11;
  localparam int unsigned OpCall  = 12;
  localparam int unsigned OpRet   = 13;
  localparam int unsigned OpHlt   = 15;

  localparam logic [3:0] AluNone   = 4'b0000;
  localparam logic [3:0] AluRegEx  = 4'b0001;
  localparam logic [3:0] AluImmMem = 4'b0010;
  localparam logic [3:0] AluImmEx  = 4'b0011;
  localparam logic [3:0] AluAddr   = 4'b0100;

  typedef enum logic [2:0] {
    StStart1, StFetch, StDecode, StExecute, StMem, StWb, StHalt, StFault
  } state_e;

endpackage

// File: rtl/sisc_mc_ctrl_if.sv
// Controller <-> IR/status/datapath bundle. master is the controller side, slave the datapath side.
interface sisc_mc_ctrl_if #(
  parameter int unsigned OPW   = 4,
  parameter int unsigned STATW = 4,
  parameter int unsigned ALUW  = 4
);
  logic [OPW-1:0]   opcode;
  logic [STATW-1:0] mm;
  logic [STATW-1:0] stat;
  logic             imem_ack;
  logic             dmem_ack;
  logic             rf_we;
  logic             wb_sel;
  logic [ALUW-1:0]  alu_op;
  logic             br_sel;
  logic             pc_rst;
  logic             pc_write;
  logic             pc_sel;
  logic             ir_load;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             stk_sel;
  logic             sp_inc;
  logic             sp_dec;
  logic             pc_stk_sel;
  logic             halted;
  logic             fault;

  modport master (
    input  opcode, mm, stat, imem_ack, dmem_ack,
    output rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel, ir_load, imem_req,
           dmem_req, dmem_we, stk_sel, sp_inc, sp_dec, pc_stk_sel, halted, fault
  );

  modport slave (
    output opcode, mm, stat, imem_ack, dmem_ack,
    input  rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel, ir_load, imem_req,
           dmem_req, dmem_we, stk_sel, sp_inc, sp_dec, pc_stk_sel, halted, fault
  );
endinterface

// File: rtl/sisc_wait_timer.sv
// Memory-handshake wait counter; tmo flags that TMO wait cycles have elapsed.
module sisc_wait_timer
  import sisc_pkg::*;
#(
  parameter int unsigned TMO = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clear,
  input  logic inc,
  output logic tmo
);

  logic [WaitW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo = (cnt_q == WaitW'(TMO));

endmodule

// File: rtl/sisc_mc_ctrl.sv
// SISC multi-cycle control FSM with handshaked memories, masked branches, halt and timeout fault.
// Define SISC_CALLRET_EN to decode CALL(12)/RET(13); otherwise they fault in DECODE.
module sisc_mc_ctrl
  import sisc_pkg::*;
#(
  parameter int unsigned OPW   = 4,
  parameter int unsigned STATW = 4,
  parameter int unsigned ALUW  = 4,
  parameter int unsigned TMO   = 15
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_mc_ctrl_if.master bus
);

`ifdef SISC_CALLRET_EN
  localparam bit CallRetEn = 1'b1;
`else
  localparam bit CallRetEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [OPW-1:0]   opc;
  logic [31:0]      op;
  logic [STATW-1:0] cc_masked;
  logic             hit, taken, legal, is_call, is_ret, is_mem;
  logic             tmr_clear, tmr_inc, tmo;
  logic [3:0]       alu_code;

  assign opc       = bus.opcode;
  assign op        = 32'(opc);
  assign cc_masked = bus.stat & bus.mm;
  assign hit       = |cc_masked;
  assign is_call   = CallRetEn && (op == OpCall);
  assign is_ret    = CallRetEn && (op == OpRet);
  assign is_mem    = (op == OpLod) || (op == OpStr) || is_call || is_ret;

  always_comb begin
    case (op)
      OpBra, OpBrr: taken = (bus.mm == '0) || hit;
      OpBne, OpBnr: taken = !hit;
      default:      taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OpNop, OpRegOp, OpRegIm, OpBra, OpBrr, OpBne, OpBnr, OpLod, OpStr, OpHlt: legal = 1'b1;
      OpCall, OpRet: legal = CallRetEn;
      default:       legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= StStart1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tmr_inc        = 1'b0;
    alu_code       = AluNone;
    bus.rf_we      = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.br_sel     = 1'b0;
    bus.pc_rst     = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.ir_load    = 1'b0;
    bus.imem_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.stk_sel    = 1'b0;
    bus.sp_inc     = 1'b0;
    bus.sp_dec     = 1'b0;
    bus.pc_stk_sel = 1'b0;
    bus.halted     = 1'b0;
    bus.fault      = 1'b0;
    unique case (state_q)
      StStart1: begin
        bus.pc_rst   = 1'b1;
        bus.pc_write = 1'b1;
        state_d      = StFetch;
      end
      StFetch: begin
        bus.imem_req = 1'b1;
        // A simultaneous ack beats the timeout.
        if (bus.imem_ack) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end else if (tmo) begin
          state_d = StFault;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      StDecode: begin
        if (taken) begin
          bus.pc_sel   = 1'b1;
          bus.pc_write = 1'b1;
          bus.br_sel   = (op == OpBra) || (op == OpBne);
        end
        if (op == OpHlt)  state_d = StHalt;
        else if (!legal)  state_d = StFault;
        else              state_d = StExecute;
      end
      StExecute: begin
        if (op == OpRegOp)                      alu_code = AluRegEx;
        else if (op == OpRegIm)                 alu_code = AluImmEx;
        else if (op == OpLod || op == OpStr)    alu_code = AluAddr;
        bus.sp_inc = is_ret;
        state_d    = StMem;
      end
      StMem: begin
        if (op == OpRegOp)                      alu_code = AluNone;
        else if (op == OpRegIm)                 alu_code = AluImmMem;
        else if (op == OpLod || op == OpStr)    alu_code = AluAddr;
        if (is_mem) begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (op == OpStr) || is_call;
          bus.stk_sel  = is_call || is_ret;
          if (bus.dmem_ack) begin
            state_d = StWb;
          end else if (tmo) begin
            state_d = StFault;
          end else begin
            tmr_inc = 1'b1;
          end
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        bus.rf_we  = (op == OpRegOp) || (op == OpRegIm) || (op == OpLod);
        bus.wb_sel = (op == OpLod);
        if (is_call) begin
          bus.sp_dec   = 1'b1;
          bus.pc_sel   = 1'b1;
          bus.br_sel   = 1'b1;
          bus.pc_write = 1'b1;
        end
        if (is_ret) begin
          bus.pc_stk_sel = 1'b1;
          bus.pc_write   = 1'b1;
        end
        state_d = StFetch;
      end
      StHalt:  bus.halted = 1'b1;
      StFault: bus.fault  = 1'b1;
    endcase
  end

  assign bus.alu_op = ALUW'(alu_code);
  assign tmr_clear  = (state_d != state_q);

  sisc_wait_timer #(
    .TMO (TMO)
  ) u_wait_timer (
    .clk   (clk),
    .rst_f (rst_f),
    .clear (tmr_clear),
    .inc   (tmr_inc),
    .tmo   (tmo)
  );

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Self-checking bench for sisc_mc_ctrl: per-cycle expected strobes derived from instruction semantics.
module tb_sisc_mc_ctrl;

  localparam int unsigned TMO = 15;
`ifdef SISC_CALLRET_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  typedef struct packed {
    logic       rf_we;
    logic       wb_sel;
    logic [3:0] alu_op;
    logic       br_sel;
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       ir_load;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       stk_sel;
    logic       sp_inc;
    logic       sp_dec;
    logic       pc_stk_sel;
    logic       halted;
    logic       fault;
  } outs_t;

  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sisc_mc_ctrl_if #(.OPW(4), .STATW(4), .ALUW(4)) bus ();

  sisc_mc_ctrl #(
    .OPW   (4),
    .STATW (4),
    .ALUW  (4),
    .TMO   (TMO)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t s;
    s.rf_we = bus.rf_we;       s.wb_sel = bus.wb_sel;     s.alu_op = bus.alu_op;
    s.br_sel = bus.br_sel;     s.pc_rst = bus.pc_rst;     s.pc_write = bus.pc_write;
    s.pc_sel = bus.pc_sel;     s.ir_load = bus.ir_load;   s.imem_req = bus.imem_req;
    s.dmem_req = bus.dmem_req; s.dmem_we = bus.dmem_we;   s.stk_sel = bus.stk_sel;
    s.sp_inc = bus.sp_inc;     s.sp_dec = bus.sp_dec;     s.pc_stk_sel = bus.pc_stk_sel;
    s.halted = bus.halted;     s.fault = bus.fault;
    return s;
  endfunction

  function automatic bit legal(input int op);
    case (op)
      0, 1, 2, 4, 5, 6, 7, 10, 11, 15: return 1'b1;
      12, 13:                          return CR;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic bit mem_access(input int op);
    return (op == 10) || (op == 11) || (CR && (op == 12 || op == 13));
  endfunction

  task automatic chk(input string tag, input outs_t e);
    outs_t got;
    got = sample();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, e);
    end
  endtask

  task automatic step(input string tag, input outs_t e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    outs_t e;
    e = '0; e.pc_rst = 1'b1; e.pc_write = 1'b1;
    rst_f = 1'b0;
    #1;
    chk("reset_async", e);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst_f = 1'b1;
    step("start1", e);
  endtask

  task automatic absorb(input bit is_halt);
    outs_t e;
    e = '0; e.halted = is_halt; e.fault = !is_halt;
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'($urandom);
      bus.dmem_ack = 1'($urandom);
      step(is_halt ? "halt_hold" : "fault_hold", e);
    end
    do_reset();
  endtask

  // Whole instruction from FETCH through WB; stops after DECODE for HLT/illegal opcodes.
  task automatic run_instr(input int op, input logic [3:0] mmv, input logic [3:0] statv,
                           input int fw, input int mw);
    outs_t e;
    bit    hit, taken;
    bus.opcode = 4'(op); bus.mm = mmv; bus.stat = statv;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < fw; i++) begin
      bus.dmem_ack = 1'($urandom);
      e = '0; e.imem_req = 1'b1;
      step("fetch_wait", e);
    end
    bus.imem_ack = 1'b1;
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    step("fetch_ack", e);
    bus.imem_ack = 1'($urandom);
    hit   = (statv & mmv) != 4'b0;
    taken = (op == 4 || op == 5) ? (mmv == 4'b0 || hit) : !hit;
    e = '0;
    if (op >= 4 && op <= 7 && taken) begin
      e.pc_sel = 1'b1; e.pc_write = 1'b1; e.br_sel = (op == 4 || op == 6);
    end
    step("decode", e);
    if (op == 15 || !legal(op)) return;
    e = '0;
    e.alu_op = (op == 1) ? 4'd1 : (op == 2) ? 4'd3 : (op == 10 || op == 11) ? 4'd4 : 4'd0;
    e.sp_inc = CR && op == 13;
    step("execute", e);
    if (mem_access(op)) begin
      for (int i = 0; i <= mw; i++) begin
        bus.dmem_ack = (i == mw);
        e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == 11 || op == 12);
        e.stk_sel = (op >= 12); e.alu_op = (op <= 11) ? 4'd4 : 4'd0;
        step("mem", e);
      end
    end else begin
      bus.dmem_ack = 1'($urandom);
      e = '0; e.alu_op = (op == 2) ? 4'd2 : 4'd0;
      step("mem_alu", e);
    end
    e = '0; e.rf_we = (op == 1 || op == 2 || op == 10); e.wb_sel = (op == 10);
    if (CR && op == 12) begin
      e.sp_dec = 1'b1; e.pc_sel = 1'b1; e.br_sel = 1'b1; e.pc_write = 1'b1;
    end
    if (CR && op == 13) begin
      e.pc_stk_sel = 1'b1; e.pc_write = 1'b1;
    end
    step("wb", e);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // Runs a load/store up to its first MEM cycle.
  task automatic pre_mem(input int op);
    outs_t e;
    bus.opcode = 4'(op); bus.mm = 4'b0; bus.stat = 4'b0;
    bus.imem_ack = 1'b1;
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    step("pre_fetch", e);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    step("pre_decode", '0);
    e = '0; e.alu_op = 4'd4;
    step("pre_execute", e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    int    op, fw, mw;
    int    legal_ops[$];
    int    ill_ops[$];
    legal_ops = '{0, 1, 2, 4, 5, 6, 7, 10, 11};
    ill_ops   = '{3, 8, 9, 14};
    if (CR) begin
      legal_ops.push_back(12); legal_ops.push_back(13);
    end else begin
      ill_ops.push_back(12); ill_ops.push_back(13);
    end
    bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    #3;
    do_reset();

    run_instr(1, 4'($urandom), 4'($urandom), 2, 0);
    run_instr(5, 4'b0001, 4'b0001, 0, 0);
    run_instr(5, 4'b0001, 4'b0000, 0, 0);
    run_instr(10, 4'($urandom), 4'($urandom), 1, 4);
    run_instr(11, 4'($urandom), 4'($urandom), 0, 2);
    run_instr(2, 4'($urandom), 4'($urandom), int'(TMO), 0);
    run_instr(11, 4'($urandom), 4'($urandom), 0, int'(TMO));

`ifdef SISC_CALLRET_EN
    run_instr(12, 4'($urandom), 4'($urandom), 0, 2);
    run_instr(13, 4'($urandom), 4'($urandom), 1, 1);
`else
    run_instr(12, 4'($urandom), 4'($urandom), 0, 0);
    absorb(1'b0);
`endif

    run_instr(15, 4'($urandom), 4'($urandom), 1, 0);
    absorb(1'b1);

    // Fetch that is never acknowledged.
    bus.imem_ack = 1'b0;
    for (int i = 0; i <= int'(TMO); i++) begin
      e = '0; e.imem_req = 1'b1;
      step("fetch_tmo_wait", e);
    end
    absorb(1'b0);

    // Load whose data ack never arrives.
    pre_mem(10);
    for (int i = 0; i <= int'(TMO); i++) begin
      e = '0; e.dmem_req = 1'b1; e.alu_op = 4'd4;
      step("mem_tmo_wait", e);
    end
    absorb(1'b0);

    // Reset in the middle of a store handshake.
    pre_mem(11);
    e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.alu_op = 4'd4;
    step("str_wait", e);
    chk("str_mid", e);
    do_reset();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) op = ill_ops[$urandom_range(0, ill_ops.size() - 1)];
      else if ($urandom_range(0, 19) == 0) op = 15;
      else op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
      fw = ($urandom_range(0, 7) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
      run_instr(op, 4'($urandom), 4'($urandom), fw, mw);
      if (op == 15) absorb(1'b1);
      else if (!legal(op)) absorb(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
